lfsr_seq_ctrl: RTL

//  Sequencer for the 16-bit Fibonacci LFSR: seeds it on a start command, then steps it only

---
 rtl/lfsr_seq_ctrl_pkg.sv | 28 ++
 rtl/lfsr_seq_ctrl_if.sv | 34 +++
 rtl/lfsr_seq_ctrl_core.sv | 33 +++
 rtl/lfsr_seq_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/lfsr_seq_ctrl_pkg.sv
// Purpose: shared constants, FSM state encoding and the LFSR step function
//          for the LFSR sequencer.
// Contents:
//   W, CNT_W    LFSR width and step-counter width
//   MAX_PERIOD  longest possible sequence for the 16-bit tap set
//   state_t     sequencer FSM encoding
//   lfsr_next() one Fibonacci step, x^16+x^14+x^13+x^11+1
package lfsr_seq_ctrl_pkg;

  localparam int W     = 16;
  localparam int CNT_W = 17;

  localparam logic [CNT_W-1:0] MAX_PERIOD = CNT_W'((1 << W) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Only valid for W = 16; the feedback taps are bits 0, 2, 3 and 5.
  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Purpose: control and stream bundle between the controller (master) and
//          the LFSR sequencer (slave).
// Signals:
//   start, abort, seed_in, max_steps   run control from the master
//   out_ready                          consumer acceptance
//   out_valid, out_data                keystream word
//   busy, done, timeout, period        run status
//   seed_err                           rejected zero-seed start pulse
interface lfsr_seq_ctrl_if;
  import lfsr_seq_ctrl_pkg::*;

  logic             start;
  logic             abort;
  logic [W-1:0]     seed_in;
  logic [CNT_W-1:0] max_steps;
  logic             out_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] period;
  logic             seed_err;

  modport master (
    output start, abort, seed_in, max_steps, out_ready,
    input  out_valid, out_data, busy, done, timeout, period, seed_err
  );

  modport slave (
    input  start, abort, seed_in, max_steps, out_ready,
    output out_valid, out_data, busy, done, timeout, period, seed_err
  );
endinterface

// File: rtl/lfsr_seq_ctrl_core.sv
// Purpose: W-bit Fibonacci LFSR register with seed load and step enable.
// Ports:
//   i_clk, i_rst  clock, async active-high reset (state -> 0)
//   i_load        load i_seed (wins over i_en)
//   i_en          advance one step
//   i_seed        seed value
//   o_state       current register value
module lfsr_seq_ctrl_core
  import lfsr_seq_ctrl_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_seed,
  output logic [W-1:0] o_state
);

  logic [W-1:0] r_state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= '0;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_en) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Purpose: seeds the LFSR on start, steps it once per accepted stream word,
//          counts accepted words and ends the run when the sequence wraps to
//          the seed or the step budget is used up.
// Ports:
//   i_clk, i_rst  clock, async active-high reset
//   io_bus        slave side of lfsr_seq_ctrl_if (control, stream, status)
//
// state   | meaning
// --------+-----------------------------------------------------
// ST_IDLE | waiting for start; zero seed is rejected here
// ST_LOAD | one cycle, LFSR loaded with the captured seed
// ST_RUN  | word presented; steps on accept, abort cancels
// ST_DONE | one cycle, done pulse, then back to idle
module lfsr_seq_ctrl
  import lfsr_seq_ctrl_pkg::*;
(
  input logic            i_clk,
  input logic            i_rst,
  lfsr_seq_ctrl_if.slave io_bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_seed;
  logic [CNT_W-1:0] r_budget;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_period;
  logic             r_timeout;
  logic             r_seed_err;

  logic             w_load;
  logic             w_en;
  logic             w_start_ok;
  logic             w_seed_rej;
  logic             w_period_hit;
  logic             w_budget_hit;
  logic [W-1:0]     w_lfsr_q;
  logic [W-1:0]     w_lfsr_nxt;
  logic [CNT_W-1:0] w_cnt_inc;

  lfsr_seq_ctrl_core u_core (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_en    (w_en),
    .i_seed  (r_seed),
    .o_state (w_lfsr_q)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_en         = 1'b0;
    w_start_ok   = 1'b0;
    w_seed_rej   = 1'b0;
    w_period_hit = 1'b0;
    w_budget_hit = 1'b0;
    w_lfsr_nxt   = lfsr_next(w_lfsr_q);
    w_cnt_inc    = (r_count == CNT_MAX) ? r_count : r_count + 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (io_bus.start) begin
          if (io_bus.seed_in != '0) begin
            w_start_ok  = 1'b1;
            w_state_nxt = ST_LOAD;
          end else begin
            w_seed_rej = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = io_bus.abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        // Abort outranks a same-cycle accept: the word is treated as not taken.
        if (io_bus.abort) begin
          w_state_nxt = ST_IDLE;
        end else if (io_bus.out_ready) begin
          w_en = 1'b1;
          // Stop before the seed would be re-presented.
          if (w_lfsr_nxt == r_seed) begin
            w_period_hit = 1'b1;
            w_state_nxt  = ST_DONE;
          end else if ((r_budget != '0) && (w_cnt_inc == r_budget)) begin
            w_budget_hit = 1'b1;
            w_state_nxt  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seed     <= '0;
      r_budget   <= '0;
      r_count    <= '0;
      r_period   <= '0;
      r_timeout  <= 1'b0;
      r_seed_err <= 1'b0;
    end else begin
      r_seed_err <= w_seed_rej;
      if (w_start_ok) begin
        r_seed    <= io_bus.seed_in;
        r_budget  <= io_bus.max_steps;
        r_count   <= '0;
        r_period  <= '0;
        r_timeout <= 1'b0;
      end else begin
        if (w_en) begin
          r_count <= w_cnt_inc;
        end
        if (w_period_hit) begin
          r_period <= w_cnt_inc;
        end else if (w_budget_hit) begin
          r_period  <= w_cnt_inc;
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign io_bus.out_valid = (r_state == ST_RUN);
  assign io_bus.out_data  = w_lfsr_q;
  assign io_bus.busy      = (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign io_bus.done      = (r_state == ST_DONE);
  assign io_bus.timeout   = r_timeout;
  assign io_bus.period    = r_period;
  assign io_bus.seed_err  = r_seed_err;

endmodule
